// File: rtl/multiplexor_paquetes_2a1.sv
// multiplexor_paquetes_2a1: round-robin 2-to-1 packet merger with a registered, source-tagged output stage
module multiplexor_paquetes_2a1 #(
  parameter int ANCHO = 8
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic [ANCHO-1:0] Entrada1,
  input  logic             Valido1,
  input  logic             Ultimo1,
  output logic             Listo1,
  input  logic [ANCHO-1:0] Entrada2,
  input  logic             Valido2,
  input  logic             Ultimo2,
  output logic             Listo2,
  output logic [ANCHO-1:0] Salida,
  output logic             ValidoSalida,
  output logic             UltimoSalida,
  output logic             Origen,
  input  logic             ListoSalida,
  output logic             Ocupado
);
  typedef enum logic [1:0] {INACTIVO, CANAL1, CANAL2} estado_t;
  estado_t r_estado;
  logic    r_turno;
  logic    w_carga, w_gana1, w_gana2, w_acepta1, w_acepta2;
  assign w_carga   = !ValidoSalida || ListoSalida;
  assign w_gana1   = Valido1 && (!Valido2 || !r_turno);
  assign w_gana2   = Valido2 && (!Valido1 || r_turno);
  assign Listo1    = !Reset && w_carga && (r_estado == CANAL1 || (r_estado == INACTIVO && w_gana1));
  assign Listo2    = !Reset && w_carga && (r_estado == CANAL2 || (r_estado == INACTIVO && w_gana2));
  assign w_acepta1 = Valido1 && Listo1;
  assign w_acepta2 = Valido2 && Listo2;
  assign Ocupado   = r_estado != INACTIVO;
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_estado     <= INACTIVO;
      r_turno      <= 1'b0;
      Salida       <= '0;
      ValidoSalida <= 1'b0;
      UltimoSalida <= 1'b0;
      Origen       <= 1'b0;
    end else if (w_acepta1 || w_acepta2) begin
      Salida       <= w_acepta2 ? Entrada2 : Entrada1;
      UltimoSalida <= w_acepta2 ? Ultimo2 : Ultimo1;
      Origen       <= w_acepta2;
      ValidoSalida <= 1'b1;
      // The last beat of a packet releases the lock and hands priority to the other channel
      if (w_acepta2 ? Ultimo2 : Ultimo1) begin
        r_estado <= INACTIVO;
        r_turno  <= !w_acepta2;
      end else begin
        r_estado <= w_acepta2 ? CANAL2 : CANAL1;
      end
    end else if (w_carga && ListoSalida) begin
      ValidoSalida <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multiplexor_paquetes_2a1.sv
// tb_multiplexor_paquetes_2a1: directed self-checking bench for the 2-to-1 packet merger
module tb_multiplexor_paquetes_2a1;
  logic       Reloj = 1'b0;
  logic       Reset;
  logic [7:0] Entrada1, Entrada2, Salida;
  logic       Valido1, Ultimo1, Listo1, Valido2, Ultimo2, Listo2;
  logic       ValidoSalida, UltimoSalida, Origen, ListoSalida, Ocupado;
  int         errors = 0;
  int         checks = 0;

  multiplexor_paquetes_2a1 #(.ANCHO(8)) dut (
    .Reloj(Reloj), .Reset(Reset),
    .Entrada1(Entrada1), .Valido1(Valido1), .Ultimo1(Ultimo1), .Listo1(Listo1),
    .Entrada2(Entrada2), .Valido2(Valido2), .Ultimo2(Ultimo2), .Listo2(Listo2),
    .Salida(Salida), .ValidoSalida(ValidoSalida), .UltimoSalida(UltimoSalida),
    .Origen(Origen), .ListoSalida(ListoSalida), .Ocupado(Ocupado)
  );

  always #5 Reloj = !Reloj;

  task automatic step();
    @(posedge Reloj);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic u, input logic o);
    chk({tag, ".Salida"}, {8'h0, Salida}, {8'h0, d});
    chk({tag, ".ValidoSalida"}, {15'h0, ValidoSalida}, {15'h0, v});
    chk({tag, ".UltimoSalida"}, {15'h0, UltimoSalida}, {15'h0, u});
    chk({tag, ".Origen"}, {15'h0, Origen}, {15'h0, o});
  endtask

  task automatic chk_listo(input string tag, input logic l1, input logic l2);
    #1;
    chk({tag, ".Listo1"}, {15'h0, Listo1}, {15'h0, l1});
    chk({tag, ".Listo2"}, {15'h0, Listo2}, {15'h0, l2});
  endtask

  initial begin
    Reset = 1'b1; ListoSalida = 1'b1;
    Entrada1 = 8'h00; Valido1 = 1'b1; Ultimo1 = 1'b1;
    Entrada2 = 8'h00; Valido2 = 1'b1; Ultimo2 = 1'b1;
    step();
    chk_listo("reset_blocks", 1'b0, 1'b0);
    Valido1 = 1'b0; Valido2 = 1'b0; Ultimo1 = 1'b0; Ultimo2 = 1'b0;
    step();
    Reset = 1'b0;
    step();
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.Ocupado", {15'h0, Ocupado}, 16'h0);
    chk_listo("idle", 1'b0, 1'b0);
    // single-beat packets
    Entrada1 = 8'h11; Valido1 = 1'b1; Ultimo1 = 1'b1;
    chk_listo("single1", 1'b1, 1'b0);
    step();
    Valido1 = 1'b0;
    chk_out("single1", 8'h11, 1'b1, 1'b1, 1'b0);
    chk("single1.Ocupado", {15'h0, Ocupado}, 16'h0);
    Entrada2 = 8'h22; Valido2 = 1'b1; Ultimo2 = 1'b1;
    chk_listo("single2", 1'b0, 1'b1);
    step();
    Valido2 = 1'b0;
    chk_out("single2", 8'h22, 1'b1, 1'b1, 1'b1);
    step();
    chk("drain.ValidoSalida", {15'h0, ValidoSalida}, 16'h0);
    // packet lock: Canal 2 starts alone, Canal 1 arrives mid-packet
    Entrada2 = 8'hA0; Valido2 = 1'b1; Ultimo2 = 1'b0;
    chk_listo("lock0", 1'b0, 1'b1);
    step();
    Entrada2 = 8'hA1; Entrada1 = 8'h55; Valido1 = 1'b1; Ultimo1 = 1'b1;
    chk_out("lockA0", 8'hA0, 1'b1, 1'b0, 1'b1);
    chk("lockA0.Ocupado", {15'h0, Ocupado}, 16'h1);
    chk_listo("lock1", 1'b0, 1'b1);
    step();
    Entrada2 = 8'hA2; Ultimo2 = 1'b1;
    chk_out("lockA1", 8'hA1, 1'b1, 1'b0, 1'b1);
    chk_listo("lock2", 1'b0, 1'b1);
    step();
    Valido2 = 1'b0;
    chk_out("lockA2", 8'hA2, 1'b1, 1'b1, 1'b1);
    chk("lockA2.Ocupado", {15'h0, Ocupado}, 16'h0);
    chk_listo("lock3", 1'b1, 1'b0);
    step();
    Valido1 = 1'b0;
    chk_out("lock55", 8'h55, 1'b1, 1'b1, 1'b0);
    // round-robin from reset
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Entrada1 = 8'h01; Valido1 = 1'b1; Ultimo1 = 1'b1;
    Entrada2 = 8'h81; Valido2 = 1'b1; Ultimo2 = 1'b1;
    chk_listo("rr0", 1'b1, 1'b0);
    step();
    Entrada1 = 8'h02;
    chk_out("rr01", 8'h01, 1'b1, 1'b1, 1'b0);
    chk_listo("rr1", 1'b0, 1'b1);
    step();
    Entrada2 = 8'h82;
    chk_out("rr81", 8'h81, 1'b1, 1'b1, 1'b1);
    step();
    chk_out("rr02", 8'h02, 1'b1, 1'b1, 1'b0);
    step();
    Valido1 = 1'b0; Valido2 = 1'b0;
    chk_out("rr82", 8'h82, 1'b1, 1'b1, 1'b1);
    // backpressure during a Canal 1 packet
    Entrada1 = 8'h31; Valido1 = 1'b1; Ultimo1 = 1'b0;
    step();
    Entrada1 = 8'h32;
    chk_out("bp31", 8'h31, 1'b1, 1'b0, 1'b0);
    ListoSalida = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_listo("bp_stall", 1'b0, 1'b0);
      step();
      chk_out("bp_hold", 8'h31, 1'b1, 1'b0, 1'b0);
    end
    ListoSalida = 1'b1;
    chk_listo("bp_release", 1'b1, 1'b0);
    step();
    Entrada1 = 8'h33; Ultimo1 = 1'b1;
    chk_out("bp32", 8'h32, 1'b1, 1'b0, 1'b0);
    step();
    Valido1 = 1'b0;
    chk_out("bp33", 8'h33, 1'b1, 1'b1, 1'b0);
    step();
    chk("bp_end.ValidoSalida", {15'h0, ValidoSalida}, 16'h0);
    // reset mid-packet
    Entrada1 = 8'h41; Valido1 = 1'b1; Ultimo1 = 1'b0;
    step();
    chk_out("rst41", 8'h41, 1'b1, 1'b0, 1'b0);
    chk("rst41.Ocupado", {15'h0, Ocupado}, 16'h1);
    Entrada1 = 8'h42; Reset = 1'b1;
    step();
    Reset = 1'b0; Valido1 = 1'b0;
    chk("rst.ValidoSalida", {15'h0, ValidoSalida}, 16'h0);
    chk("rst.Ocupado", {15'h0, Ocupado}, 16'h0);
    Entrada2 = 8'hB0; Valido2 = 1'b1; Ultimo2 = 1'b1;
    chk_listo("rst_grant", 1'b0, 1'b1);
    step();
    Valido2 = 1'b0;
    chk_out("rstB0", 8'hB0, 1'b1, 1'b1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiplexor_paquetes_2a1.md
# multiplexor_paquetes_2a1

- Merges two packet streams, Canal 1 and Canal 2, onto one output stream. It performs the inverse of the 1-to-2 demultiplexor.
- Uses valid/ready handshakes on all three channels.
- Arbitration is round-robin, but it only changes at packet boundaries. A packet is a run of beats ending with `Ultimo` = 1.
- A registered output stage tags every beat with its source channel, so a downstream demultiplexor can route it back.

## Interface
- `ANCHO`, 8, data width in bits of each channel.
- `Reloj` input 1: the single clock. All state changes on its rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Entrada1` input ANCHO: Canal 1 data.
- `Valido1` input 1: Canal 1 beat valid.
- `Ultimo1` input 1: Canal 1 beat is the last of its packet.
- `Listo1` output 1: Canal 1 beat accepted this cycle.
- `Entrada2`, `Valido2`, `Ultimo2`, `Listo2`: same as Canal 1, for Canal 2.
- `Salida` output ANCHO: output data (registered).
- `ValidoSalida` output 1: output beat valid (registered).
- `UltimoSalida` output 1: output beat is the last of its packet (registered).
- `Origen` output 1: source of the output beat, 0 = Canal 1, 1 = Canal 2 (registered).
- `ListoSalida` input 1: the downstream stage accepts the output beat.
- `Ocupado` output 1: high while a packet is locked, i.e. state is not INACTIVO.

## Operation
- States:
  - INACTIVO: no packet in progress.
  - CANAL1: locked to Canal 1 mid-packet.
  - CANAL2: locked to Canal 2 mid-packet.
- Internal `Turno` (1 bit) is the preferred channel for the next arbitration. 0 = Canal 1.
- `carga = !ValidoSalida || ListoSalida`. The output register can take a new beat this cycle.
- Winner in INACTIVO:
  - Only `Valido1` high: Canal 1 wins.
  - Only `Valido2` high: Canal 2 wins.
  - Both high: the channel selected by `Turno` wins.
  - Neither high: no winner.
- `Listo1 = carga && (estado==CANAL1 || (estado==INACTIVO && Canal 1 wins))`. `Listo2` is symmetric. Both are combinational.
- The losing channel, and any channel other than the locked one, sees `Listo` = 0 regardless of its `Valido`.
- A beat is accepted on channel k when `Valido_k && Listo_k`. On the next edge:
  - `Salida`/`UltimoSalida` take `Entrada_k`/`Ultimo_k`.
  - `Origen` takes k-1.
  - `ValidoSalida` = 1.
- Accepted beat with `Ultimo_k` = 0: state becomes CANALk.
- Accepted beat with `Ultimo_k` = 1: state becomes INACTIVO and `Turno` becomes the other channel. This covers single-beat packets accepted from INACTIVO.
- In CANALk with `Valido_k` = 0: the state holds and the other channel stays blocked. Packets are never interleaved.
- `carga` high and no beat accepted: `ValidoSalida` takes 0 if `ListoSalida` was high, otherwise it holds.
- `carga` low: the output register and all its fields hold unchanged (stall).
- `Ocupado = (estado != INACTIVO)`.
- Upstream rule: a source holds `Entrada`/`Ultimo` stable while `Valido` is high and `Listo` is low. The block does not check this.

## Timing
- Reset values:
  - `Salida` = 0, `ValidoSalida` = 0, `UltimoSalida` = 0, `Origen` = 0.
  - `Ocupado` = 0, state INACTIVO, `Turno` = 0.
  - `Listo1`/`Listo2` follow combinationally and are 0 while `Reset` is high.
- `Reset` asserted mid-packet or with a beat pending: the lock and the held beat are discarded. No partial output is completed.
- Latency: a beat accepted at edge N appears on `Salida` with `ValidoSalida` = 1 after edge N.
- Throughput is 1 beat/cycle when `ListoSalida` is held high, including between consecutive packets. INACTIVO arbitrates in the same cycle it is entered, with no bubble.
- Backpressure: while `ValidoSalida` = 1 and `ListoSalida` = 0, both `Listo` outputs are 0 and the output holds.
- Simultaneous events:
  - Drain and load in the same cycle replace the output beat, and `ValidoSalida` stays 1.
  - Both `Valido` inputs rising in the same cycle are resolved by `Turno`.

## Test plan
- Reset, then both channels idle and `ListoSalida` = 1: all outputs are 0, state INACTIVO.
- Single-beat packets:
  - Stimulus: Canal 1 sends 0x11 with `Ultimo` = 1 at cycle 2; `ListoSalida` = 1.
  - Response: cycle 3 shows `Salida` = 0x11, `Origen` = 0, `UltimoSalida` = 1, `ValidoSalida` = 1.
  - Canal 2 then sends 0x22 the same way: output 0x22 with `Origen` = 1.
- Packet lock:
  - Stimulus: Canal 2 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (`Ultimo` on 0xA2) while Canal 1 holds `Valido1` = 1 with 0x55.
  - Response: `Listo1` = 0 for all three beats. The output sequence is A0, A1, A2 (`Origen` = 1), then 0x55 (`Origen` = 0) on the next cycle with no bubble.
- Round-robin:
  - Stimulus: both channels continuously present single-beat packets (Canal 1: 0x01, 0x02…; Canal 2: 0x81, 0x82…) from reset.
  - Response: output is 0x01, 0x81, 0x02, 0x82, alternating `Origen` 0,1,0,1.
- Backpressure:
  - Stimulus: during a Canal 1 packet, `ListoSalida` = 0 for 3 cycles.
  - Response: `Salida` and `ValidoSalida` hold, `Listo1` = 0, and no beat is lost or duplicated once `ListoSalida` returns to 1.
- Reset mid-packet:
  - Stimulus: assert `Reset` after beat 1 of a 4-beat Canal 1 packet.
  - Response: the next cycle shows `ValidoSalida` = 0 and `Ocupado` = 0. A Canal 2 packet presented afterward is granted immediately.
